// File: rtl/loom_multi_scan_ctrl.sv
// Multi-chain scan sequencer: capture, restore or swap of NumChains chains.
// Optional abort support is enabled by defining LOOM_SCAN_ABORT_EN.
module loom_multi_scan_ctrl #(
    parameter int unsigned NumChains  = 4,
    parameter int unsigned CountWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    input  logic [1:0]            cmd_i,
    input  logic [CountWidth-1:0] shift_count_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [NumChains-1:0]  in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [NumChains-1:0]  out_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CountWidth-1:0] remaining_o,
    output logic                  scan_enable_o,
    output logic [NumChains-1:0]  scan_in_o,
    input  logic [NumChains-1:0]  scan_out_i,
    output logic                  clk_gate_en_o
`ifdef LOOM_SCAN_ABORT_EN
    ,
    input  logic                  abort_i,
    output logic                  aborted_o
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StComplete
    } state_e;

    localparam logic [1:0] CmdNop     = 2'd0;
    localparam logic [1:0] CmdCapture = 2'd1;
    localparam logic [1:0] CmdRestore = 2'd2;
    localparam logic [1:0] CmdSwap    = 2'd3;

    state_e                  state_q;
    state_e                  state_d;
    logic [1:0]              cmd_q;
    logic [CountWidth-1:0]   rem_q;

    logic accept;
    logic rem_nz;
    logic do_cap;
    logic do_rst;
    logic in_ok;
    logic out_ok;
    logic abort_act;
    logic active;
    logic fire;

    assign accept = (state_q == StIdle) && cmd_valid_i && (cmd_i != CmdNop);
    assign rem_nz = (rem_q != '0);
    assign do_cap = (cmd_q == CmdCapture) || (cmd_q == CmdSwap);
    assign do_rst = (cmd_q == CmdRestore) || (cmd_q == CmdSwap);
    assign in_ok  = !do_rst || in_valid_i;
    assign out_ok = !do_cap || out_ready_i;

`ifdef LOOM_SCAN_ABORT_EN
    assign abort_act = abort_i &&
                       ((state_q == StSetup) || (state_q == StShift));
`else
    assign abort_act = 1'b0;
`endif

    // Stream handshakes are only offered while a shift could actually fire.
    assign active = (state_q == StShift) && rem_nz && !abort_act;
    assign fire   = active && in_ok && out_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q <= CmdNop;
            rem_q <= '0;
        end else if (accept) begin
            cmd_q <= cmd_i;
            rem_q <= shift_count_i;
        end else if (fire) begin
            rem_q <= rem_q - CountWidth'(1);
        end
    end

`ifdef LOOM_SCAN_ABORT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aborted_o <= 1'b0;
        end else if (accept) begin
            aborted_o <= 1'b0;
        end else if (abort_act) begin
            aborted_o <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StSetup;
            end
            StSetup: begin
                state_d = abort_act ? StComplete : StShift;
            end
            StShift: begin
                if (abort_act || !rem_nz) state_d = StComplete;
            end
            StComplete: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o        = 1'b0;
        done_o        = 1'b0;
        scan_enable_o = 1'b0;
        clk_gate_en_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                clk_gate_en_o = 1'b1;
            end
            StSetup: begin
                busy_o        = 1'b1;
                scan_enable_o = 1'b1;
            end
            StShift: begin
                busy_o        = 1'b1;
                scan_enable_o = 1'b1;
                clk_gate_en_o = fire;
            end
            StComplete: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                clk_gate_en_o = 1'b1;
            end
        endcase
    end

    assign out_valid_o = active && do_cap && in_ok;
    assign in_ready_o  = active && do_rst && out_ok;
    assign out_data_o  = scan_out_i;
    assign remaining_o = rem_q;
    assign scan_in_o   = (do_rst && ((state_q == StSetup) ||
                                     (state_q == StShift)))
                         ? in_data_i : '0;

endmodule
